// File: rtl/pedestrian_signal.sv
// rtl/pedestrian_signal.sv - pedestrian crossing controller slaved to the traffic-light lamps
// Debounced push-button request, walk granted only at a clean red rise, then a flashing clearance phase.
module pedestrian_signal #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int WALK_CYCLES     = 120,
  parameter int FLASH_CYCLES    = 60,
  parameter int FLASH_HALF      = 5
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       green,
  input  logic       yellow,
  input  logic       red,
  input  logic       button,
  output logic       walk,
  output logic       dont_walk,
  output logic       request_pending,
  output logic [7:0] countdown
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int WW = $clog2(WALK_CYCLES + 1);
  localparam int PW = $clog2(FLASH_HALF + 1);

  typedef enum logic [1:0] {IDLE, WALK, FLASH} state_t;

  state_t          state, state_next;
  logic            sync1, b_s;
  logic [DW-1:0]   deb_cnt;
  logic            press;
  logic            red_q;
  logic            valid, red_rise, serve, lamp_ok;
  logic [WW-1:0]   walk_cnt;
  logic [7:0]      flash_cnt;
  logic [PW-1:0]   phase_cnt;
  logic            flash_on;

  // odd number of lamps lit, but not all three, means exactly one
  assign valid    = (green ^ yellow ^ red) & ~(green & yellow & red);
  assign red_rise = red & ~red_q & valid;
  assign lamp_ok  = red & valid;
  assign press    = b_s && (deb_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign serve    = (state == IDLE) && red_rise && request_pending;

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1           <= 1'b0;
      b_s             <= 1'b0;
      deb_cnt         <= '0;
      red_q           <= 1'b1;
      request_pending <= 1'b0;
    end else begin
      sync1 <= button;
      b_s   <= sync1;
      red_q <= red;
      if (!b_s)
        deb_cnt <= '0;
      else if (deb_cnt != DW'(DEBOUNCE_CYCLES))
        deb_cnt <= deb_cnt + 1'b1;
      if (serve)
        request_pending <= 1'b0;
      else if (press)
        request_pending <= 1'b1;
    end
  end

  // state register plus the per-phase timers, which restart whenever their phase is not active
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      walk_cnt  <= '0;
      flash_cnt <= 8'(FLASH_CYCLES);
      phase_cnt <= '0;
      flash_on  <= 1'b1;
    end else begin
      state <= state_next;
      if (state == WALK)
        walk_cnt <= walk_cnt + 1'b1;
      else
        walk_cnt <= '0;
      if (state == FLASH) begin
        flash_cnt <= flash_cnt - 8'd1;
        if (phase_cnt == PW'(FLASH_HALF - 1)) begin
          phase_cnt <= '0;
          flash_on  <= ~flash_on;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
      end else begin
        flash_cnt <= 8'(FLASH_CYCLES);
        phase_cnt <= '0;
        flash_on  <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (serve) state_next = WALK;
      WALK: begin
        if (!lamp_ok)
          state_next = IDLE;
        else if (walk_cnt == WW'(WALK_CYCLES - 1))
          state_next = FLASH;
      end
      FLASH: begin
        if (!lamp_ok || flash_cnt == 8'd1)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    countdown = 8'd0;
    case (state)
      WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      FLASH: begin
        dont_walk = flash_on;
        countdown = flash_cnt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pedestrian_signal.sv
// tb/tb_pedestrian_signal.sv - randomized bench for pedestrian_signal against a behavioural model
// Model tracks elapsed time per phase and run length of the synchronized button.
module tb_pedestrian_signal;

  localparam int DEB   = 4;
  localparam int WALKC = 120;
  localparam int FLASH = 60;
  localparam int HALF  = 5;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       green = 1'b0, yellow = 1'b0, red = 1'b1, button = 1'b0;
  logic       walk, dont_walk, request_pending;
  logic [7:0] countdown;

  int total = 0;
  int bad = 0;

  // model state
  int m_s1, m_s2, m_run, m_mode, m_t;
  bit m_pend, m_redq;

  // random button driver
  int btn_left = 0;
  int gap_left = 0;

  int walk_hi, flash_seen, first_cd;

  pedestrian_signal #(
    .DEBOUNCE_CYCLES(DEB), .WALK_CYCLES(WALKC), .FLASH_CYCLES(FLASH), .FLASH_HALF(HALF)
  ) dut (
    .clock(clock), .rst(rst), .green(green), .yellow(yellow), .red(red), .button(button),
    .walk(walk), .dont_walk(dont_walk), .request_pending(request_pending), .countdown(countdown)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit v, rr, press, serve;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_run = 0; m_pend = 0; m_mode = 0; m_t = 0; m_redq = 1;
      return;
    end
    v  = (int'(green) + int'(yellow) + int'(red)) == 1;
    rr = red && !m_redq && v;
    // a press is the moment the synchronized button has been high DEB samples in a row
    m_run = m_s2 ? m_run + 1 : 0;
    if (m_run > 1000) m_run = 1000;
    press = (m_run == DEB);
    serve = 0;
    case (m_mode)
      0: if (rr && m_pend) begin m_mode = 1; m_t = 0; serve = 1; end
      1: if (!red || !v) m_mode = 0;
         else if (m_t == WALKC - 1) begin m_mode = 2; m_t = 0; end
         else m_t++;
      default: if (!red || !v) m_mode = 0;
         else if (m_t == FLASH - 1) m_mode = 0;
         else m_t++;
    endcase
    if (serve) m_pend = 0;
    else if (press) m_pend = 1;
    m_s2 = m_s1; m_s1 = int'(button); m_redq = red;
  endtask

  task automatic tick();
    int e_walk, e_dw, e_cd;
    @(posedge clock);
    model_step();
    @(negedge clock);
    e_walk = (m_mode == 1);
    e_dw   = (m_mode == 0) ? 1 : (m_mode == 1) ? 0 : (((m_t / HALF) % 2) == 0);
    e_cd   = (m_mode == 2) ? FLASH - m_t : 0;
    check("walk", walk, e_walk);
    check("dont_walk", dont_walk, e_dw);
    check("countdown", countdown, e_cd);
    check("request_pending", request_pending, m_pend);
    if (walk && dont_walk) check("heads_exclusive", 1, 0);
    if (walk) walk_hi++;
    if (countdown != 0) begin
      if (flash_seen == 0) first_cd = countdown;
      flash_seen++;
    end
  endtask

  task automatic set_lamps(input logic g, input logic y, input logic r);
    green = g; yellow = y; red = r;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_for(input int n);
    button = 1'b1;
    ticks(n);
    button = 1'b0;
  endtask

  task automatic rand_button();
    if (btn_left > 0) begin
      btn_left--;
      button = (btn_left != 0);
    end else if (gap_left > 0) begin
      gap_left--;
    end else if ($urandom_range(0, 40) == 0) begin
      btn_left = $urandom_range(1, 12);
      gap_left = $urandom_range(2, 30);
      button = 1'b1;
    end
  endtask

  task automatic rand_phase(input logic g, input logic y, input logic r, input int len);
    for (int i = 0; i < len; i++) begin
      set_lamps(g, y, r);
      if ($urandom_range(0, 200) == 0) set_lamps(1'b1, 1'b0, 1'b1);
      else if ($urandom_range(0, 300) == 0) set_lamps(1'b0, 1'b0, 1'b0);
      rand_button();
      rst = ($urandom_range(0, 4000) == 0);
      tick();
      rst = 1'b0;
    end
  endtask

  initial begin
    // reset with red already lit: no walk may follow
    ticks(3);
    rst = 1'b0;
    ticks(20);
    check("reset_no_walk", walk_hi, 0);

    // short bounce then a real press, red held so nothing is served
    press_for(3);
    ticks(6);
    check("bounce_ignored", request_pending, 0);
    press_for(10);
    ticks(4);
    check("one_request", request_pending, 1);

    // full cycle with the pending request
    set_lamps(1, 0, 0); ticks(10);
    set_lamps(0, 1, 0); ticks(5);
    walk_hi = 0; flash_seen = 0; first_cd = 0;
    set_lamps(0, 0, 1); ticks(250);
    check("walk_len", walk_hi, WALKC);
    check("flash_len", flash_seen, FLASH);
    check("flash_first_cd", first_cd, FLASH);

    // press while red already lit: served only at the next red rise
    walk_hi = 0;
    press_for(8); ticks(20);
    check("mid_red_no_walk", walk_hi, 0);
    set_lamps(1, 0, 0); ticks(10);
    set_lamps(0, 1, 0); ticks(5);
    set_lamps(0, 0, 1); ticks(3);
    check("next_red_walk", walk, 1);

    // abort 30 cycles into walk
    ticks(27);
    set_lamps(1, 0, 0); tick();
    check("abort_walk", walk, 0);
    check("abort_dont_walk", dont_walk, 1);
    ticks(5);

    // invalid lamps at the red rise keep the request pending
    press_for(8); ticks(3);
    set_lamps(0, 1, 0); ticks(5);
    set_lamps(1, 0, 1); ticks(4);
    set_lamps(0, 0, 1); ticks(10);
    check("invalid_no_walk", walk, 0);
    check("invalid_keeps_req", request_pending, 1);

    for (int r = 0; r < 60; r++) begin
      rand_phase(1, 0, 0, $urandom_range(5, 40));
      rand_phase(0, 1, 0, $urandom_range(3, 10));
      rand_phase(0, 0, 1, $urandom_range(20, 260));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pedestrian_signal.md
# pedestrian_signal

Pedestrian crossing controller downstream of the traffic-light controller (`Semaforo`). Consumes its `green`/`yellow`/`red` lamp outputs and a raw pedestrian push-button. Drives the walk / don't-walk heads and a flash-phase countdown. Grants a walk phase only at the start of a red phase, and only when a debounced request is pending.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized-high samples that make a valid press (≥1).
- `WALK_CYCLES`, default 120: steady-walk duration in cycles (≥1).
- `FLASH_CYCLES`, default 60: flashing don't-walk duration in cycles (1..255).
- `FLASH_HALF`, default 5: half-period of the flash, in cycles (≥1).
- `clock`, input, 1: single clock; all logic on its rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `green`, input, 1: lamp state from the traffic light.
- `yellow`, input, 1: lamp state from the traffic light.
- `red`, input, 1: lamp state from the traffic light.
- `button`, input, 1: raw asynchronous push-button, active-high.
- `walk`, output, 1: walk head on.
- `dont_walk`, output, 1: don't-walk head on.
- `request_pending`, output, 1: a press is latched and not yet served.
- `countdown`, output, 8: remaining FLASH cycles; 0 outside FLASH.

## Operation
- **Reset values:**
  - `walk`=0, `dont_walk`=1, `request_pending`=0, `countdown`=0.
  - State is IDLE; synchronizer flops are 0; debounce counter is 0.
  - `red_q` (registered `red`) is 1, so a red lamp already present after reset is not seen as a rising edge.
- **Button path:**
  - Two-flop synchronizer produces `b_s`.
  - Debounce counter increments while `b_s`=1 and clears when `b_s`=0. It saturates at `DEBOUNCE_CYCLES`.
  - A press event fires once, on the cycle the counter reaches `DEBOUNCE_CYCLES`.
  - Holding the button does not re-fire. Release (`b_s`=0) re-arms the counter.
- **Request latch:** a press event sets `request_pending`. A press while already pending has no effect.
- **Lamp validity:** `valid` = exactly one of `green`/`yellow`/`red` is high.
- **Red rise:** `red_rise` = `red` & ~`red_q` & `valid`.
- **FSM state IDLE:**
  - Outputs: `walk`=0, `dont_walk`=1.
  - If `red_rise` and `request_pending` are both 1 (pending value registered before this cycle), go to WALK and clear `request_pending`.
- **FSM state WALK:**
  - Outputs: `walk`=1, `dont_walk`=0.
  - Lasts exactly `WALK_CYCLES` cycles, then go to FLASH.
- **FSM state FLASH:**
  - `walk`=0.
  - `dont_walk` is 1 for the first `FLASH_HALF` cycles, then 0 for `FLASH_HALF`, and so on. The phase starts fresh on FLASH entry.
  - `countdown` = `FLASH_CYCLES` in the first FLASH cycle and decrements by 1 per cycle, reaching 1 in the last.
  - After `FLASH_CYCLES` cycles, go to IDLE.
- **Abort:** in WALK or FLASH, if `red`=0 or `valid`=0, go to IDLE on the next edge with safe outputs. The served request stays cleared.
- **Invariant:** `walk` and `dont_walk` are never both 1. `walk`=1 only in WALK.
- **Presses during WALK/FLASH:** latch a new request, served at the next red rise.

## Timing
- Press latency: with `button` held high, `request_pending` rises `DEBOUNCE_CYCLES`+2 edges after the first edge sampling `button`=1. This is 2 edges of synchronizer plus `DEBOUNCE_CYCLES` edges of counting.
- Walk latency: `walk` rises on the edge after the cycle where `red_rise`=1. On that same edge, `request_pending` falls.
- WALK phase: `walk` high for exactly `WALK_CYCLES` cycles.
- FLASH phase: lasts exactly `FLASH_CYCLES` cycles, then steady `dont_walk`=1.
- Abort latency: one edge from `red`=0 or an invalid lamp combination to `walk`=0 and `dont_walk`=1.
- Simultaneous press event and `red_rise` in the same cycle: the request is latched but not served on this red.
- Red falls on the same edge WALK would end: abort wins; the FSM goes to IDLE, not FLASH.
- `rst` asserted mid-WALK or mid-FLASH: reset values apply after that edge; pending requests are lost.
- Counters are wide enough for their parameters. `countdown` is zero-extended to 8 bits.

## Test plan
- **Reset with red already high:** `rst` with `red`=1, then release → no walk; `walk`=0, `dont_walk`=1, `countdown`=0 throughout.
- **Debounce:** `button` high for 3 cycles, then low → no `request_pending`. Then high for 10 cycles → `request_pending`=1 exactly 6 edges after the first high sample; one request only.
- **Full cycle** (defaults; green→yellow→red sequence, pending request):
  - `walk`=1 one edge after red rise, for 120 cycles.
  - Then 60 cycles of `dont_walk` toggling every 5 cycles, with `countdown` running 60→1.
  - Then IDLE.
- **Mid-red press:** press while red is already high → no walk this red; walk starts at the next red rise.
- **Abort:** `red` drops 30 cycles into WALK → `walk`=0 and `dont_walk`=1 next edge; `countdown`=0.
- **Invalid lamps:** `green`=`red`=1 at a red rise with a pending request → no walk; `request_pending` stays 1.
